// File: rtl/bcd2bin_seq.sv
// Sequential signed 3-digit BCD to two's-complement converter.
// Uses reverse double-dabble with a start/busy/done handshake.
module bcd2bin_seq #(
  parameter int unsigned WORD_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             H,
  input  logic [3:0]             T,
  input  logic [3:0]             U,
  input  logic                   sign,
  output logic [WORD_LENGTH-1:0] bin,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int unsigned BCD_W     = 12;
  localparam int unsigned MAG_W     = 10;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned SH_W      = BCD_W + MAG_W;
  localparam int unsigned LAST_ITER = 9;
  localparam int unsigned MAX_POS   = (1 << (WORD_LENGTH - 1)) - 1;
  localparam int unsigned MAX_NEG   = 1 << (WORD_LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                 r_state;
  logic [BCD_W-1:0]       r_bcd;
  logic [MAG_W-1:0]       r_mag;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_sign;
  logic                   r_invalid;
  logic [WORD_LENGTH-1:0] r_bin;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;

  state_t                 w_state_nxt;
  logic [BCD_W-1:0]       w_bcd_nxt;
  logic [MAG_W-1:0]       w_mag_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_sign_nxt;
  logic                   w_invalid_nxt;
  logic [WORD_LENGTH-1:0] w_bin_nxt;
  logic                   w_done_nxt;
  logic                   w_error_nxt;

  logic [SH_W-1:0]        w_shift;
  logic [BCD_W-1:0]       w_bcd_adj;
  logic [3:0]             w_digit;
  logic [MAG_W-1:0]       w_neg;
  logic [MAG_W-1:0]       w_res;
  logic                   w_err;

  assign bin   = r_bin;
  assign busy  = r_busy;
  assign done  = r_done;
  assign error = r_error;

  // One reverse double-dabble step: shift right, then pull each digit >= 8 down by 3.
  always_comb begin
    w_shift   = {r_bcd, r_mag} >> 1;
    w_bcd_adj = w_shift[SH_W-1:MAG_W];
    w_digit   = 4'd0;
    for (int i = 0; i < 3; i++) begin
      w_digit = w_shift[MAG_W + 4*i +: 4];
      w_bcd_adj[4*i +: 4] = (w_digit >= 4'd8) ? (w_digit - 4'd3) : w_digit;
    end
  end

  // Range check and negation stay at full 10-bit magnitude before truncation.
  always_comb begin
    w_neg = ~r_mag + MAG_W'(1);
    w_res = r_sign ? r_mag : w_neg;
    w_err = r_invalid |
            (r_sign ? (r_mag > MAG_W'(MAX_POS)) : (r_mag > MAG_W'(MAX_NEG)));
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bcd_nxt     = r_bcd;
    w_mag_nxt     = r_mag;
    w_cnt_nxt     = r_cnt;
    w_sign_nxt    = r_sign;
    w_invalid_nxt = r_invalid;
    w_bin_nxt     = r_bin;
    w_error_nxt   = r_error;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_bcd_nxt     = {H, T, U};
          w_mag_nxt     = '0;
          w_cnt_nxt     = '0;
          w_sign_nxt    = sign;
          w_invalid_nxt = (H > 4'd9) | (T > 4'd9) | (U > 4'd9);
          w_state_nxt   = w_invalid_nxt ? S_FINISH : S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_bcd_nxt = w_bcd_adj;
        w_mag_nxt = w_shift[MAG_W-1:0];
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(LAST_ITER)) begin
          w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
        if (w_err) begin
          w_bin_nxt   = '0;
          w_error_nxt = 1'b1;
        end else begin
          w_bin_nxt   = WORD_LENGTH'(w_res);
          w_error_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bcd     <= '0;
      r_mag     <= '0;
      r_cnt     <= '0;
      r_sign    <= 1'b0;
      r_invalid <= 1'b0;
      r_bin     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bcd     <= w_bcd_nxt;
      r_mag     <= w_mag_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sign    <= w_sign_nxt;
      r_invalid <= w_invalid_nxt;
      r_bin     <= w_bin_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed self-checking bench for bcd2bin_seq (WORD_LENGTH = 8).
module tb_bcd2bin_seq;

  localparam int unsigned WL = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic [3:0]    H;
  logic [3:0]    T;
  logic [3:0]    U;
  logic          sign;
  logic [WL-1:0] bin;
  logic          busy;
  logic          done;
  logic          error;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int nbusy;
  int ndone;

  bcd2bin_seq #(.WORD_LENGTH(WL)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .H     (H),
    .T     (T),
    .U     (U),
    .sign  (sign),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one capture edge; returns on the negedge after capture.
  task automatic launch(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u,
                        input logic s);
    @(negedge clk);
    H = h; T = t; U = u; sign = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedge samples (current one = 1) until done; 99 on timeout.
  task automatic wait_done(output int n, output int nb);
    n  = 1;
    nb = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) n = 99;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; H = 4'd0; T = 4'd0; U = 4'd0; sign = 1'b1;
    #12;
    check("rst_bin",   32'(bin),   32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_done",  32'(done),  32'h0);
    check("rst_error", 32'(error), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // +127: largest positive for 8 bits
    launch(4'd1, 4'd2, 4'd7, 1'b1);
    wait_done(lat, nbusy);
    check("p127_lat",   32'(lat),   32'd12);
    check("p127_busy",  32'(nbusy), 32'd11);
    check("p127_busy_at_done", 32'(busy), 32'h0);
    check("p127_bin",   32'(bin),   32'h7F);
    check("p127_err",   32'(error), 32'h0);
    @(negedge clk);
    check("p127_done_pulse", 32'(done), 32'h0);
    check("p127_bin_hold",   32'(bin),  32'h7F);

    // -128 in range, +128 out of range
    launch(4'd1, 4'd2, 4'd8, 1'b0);
    wait_done(lat, nbusy);
    check("n128_lat", 32'(lat),   32'd12);
    check("n128_bin", 32'(bin),   32'h80);
    check("n128_err", 32'(error), 32'h0);
    launch(4'd1, 4'd2, 4'd8, 1'b1);
    wait_done(lat, nbusy);
    check("p128_lat", 32'(lat),   32'd12);
    check("p128_bin", 32'(bin),   32'h00);
    check("p128_err", 32'(error), 32'h1);
    @(negedge clk);
    check("p128_err_hold", 32'(error), 32'h1);

    // negative zero and -45
    launch(4'd0, 4'd0, 4'd0, 1'b0);
    wait_done(lat, nbusy);
    check("n0_lat", 32'(lat),   32'd12);
    check("n0_bin", 32'(bin),   32'h00);
    check("n0_err", 32'(error), 32'h0);
    launch(4'd0, 4'd4, 4'd5, 1'b0);
    wait_done(lat, nbusy);
    check("n45_lat", 32'(lat),   32'd12);
    check("n45_bin", 32'(bin),   32'hD3);
    check("n45_err", 32'(error), 32'h0);

    // +999 far out of range
    launch(4'd9, 4'd9, 4'd9, 1'b1);
    wait_done(lat, nbusy);
    check("p999_bin", 32'(bin),   32'h00);
    check("p999_err", 32'(error), 32'h1);

    // invalid tens digit: short path through FINISH
    launch(4'd1, 4'hA, 4'd3, 1'b1);
    wait_done(lat, nbusy);
    check("inv_lat",  32'(lat),   32'd2);
    check("inv_busy", 32'(nbusy), 32'd1);
    check("inv_bin",  32'(bin),   32'h00);
    check("inv_err",  32'(error), 32'h1);

    // start held during SHIFT with new digits is ignored
    launch(4'd1, 4'd2, 4'd7, 1'b1);
    H = 4'd0; T = 4'd4; U = 4'd5; sign = 1'b0; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(lat, nbusy);
    check("busy_start_lat", 32'(lat),   32'd9);
    check("busy_start_bin", 32'(bin),   32'h7F);
    check("busy_start_err", 32'(error), 32'h0);

    // start in the done cycle is accepted
    H = 4'd0; T = 4'd4; U = 4'd5; sign = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, nbusy);
    check("done_start_lat", 32'(lat), 32'd12);
    check("done_start_bin", 32'(bin), 32'hD3);

    // async reset at iteration 5 aborts with no done pulse
    launch(4'd0, 4'd9, 4'd9, 1'b1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_bin",   32'(bin),   32'h0);
    check("abort_busy",  32'(busy),  32'h0);
    check("abort_done",  32'(done),  32'h0);
    check("abort_error", 32'(error), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    launch(4'd0, 4'd9, 4'd9, 1'b1);
    wait_done(lat, nbusy);
    check("p99_lat", 32'(lat),   32'd12);
    check("p99_bin", 32'(bin),   32'h63);
    check("p99_err", 32'(error), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
